// File: rtl/bcd_xs3_sequencer_if.sv
// bcd_xs3_sequencer_if: request/result bundle between a packed-digit producer and the code converter.
interface bcd_xs3_sequencer_if #(parameter int DIGITS = 4);
    logic                start;
    logic                dir;
    logic [4*DIGITS-1:0] din;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] dout;
    logic                err;
    modport master (output start, dir, din, input busy, done, dout, err);
    modport slave  (input start, dir, din, output busy, done, dout, err);
endinterface

// File: rtl/bcd_xs3_sequencer.sv
// bcd_xs3_sequencer: BCD <-> excess-3 word converter, one digit per clock through a single shared adder/subtractor.
module bcd_xs3_sequencer #(parameter int DIGITS = 4) (
    input logic                clk,
    input logic                rst_n,
    bcd_xs3_sequencer_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state, state_n;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] src, dout_q;
    logic                dir_q, err_q, accept, last, bad;
    logic [3:0]          dig, sum;
    logic                unused_cout;
    assign dig  = src[{idx, 2'b00} +: 4];
    assign last = idx == IW'(DIGITS - 1);
    assign bad  = dir_q ? (dig < 4'd3 || dig > 4'd12) : dig > 4'd9;
    adder_subtractor u_addsub (
        .a    (dig),
        .b    (4'b0011),
        .m    (dir_q),
        .s    (sum),
        .cout (unused_cout)
    );
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        if (state == RUN) begin
            state_n = last ? DONE : RUN;
        end else begin
            accept  = bus.start;
            state_n = bus.start ? RUN : IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            src    <= '0;
            dir_q  <= 1'b0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                src   <= bus.din;
                dir_q <= bus.dir;
                idx   <= '0;
                err_q <= 1'b0;
            end else if (state == RUN) begin
                dout_q[{idx, 2'b00} +: 4] <= bad ? 4'hF : sum;
                err_q <= err_q | bad;
                idx   <= idx + 1'b1;
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.dout = dout_q;
    assign bus.err  = err_q;
endmodule

module adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic       cout
);
    // m=1 turns the add into a - b via two's complement of b
    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {4{m}}} + {4'b0000, m};
endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// tb_bcd_xs3_sequencer: directed and randomized checks of the BCD/excess-3 sequencer against a per-digit arithmetic model.
module tb_bcd_xs3_sequencer;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;
    bcd_xs3_sequencer_if #(.DIGITS(D)) bus ();
    bcd_xs3_sequencer #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // word-level reference: each digit judged and converted on its own value
    function automatic logic [16:0] model(input logic [15:0] d, input logic r);
        logic [15:0] o = '0;
        logic        e = 1'b0;
        for (int k = 0; k < D; k++) begin
            int v = int'(d[4*k +: 4]);
            bit ok = r ? (v >= 3 && v <= 12) : (v <= 9);
            o[4*k +: 4] = ok ? 4'(r ? v - 3 : v + 3) : 4'hF;
            e |= !ok;
        end
        return {e, o};
    endfunction

    task automatic start_conv(input logic [15:0] d, input logic r);
        bus.start = 1'b1;
        bus.din   = d;
        bus.dir   = r;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish_conv(input string tag, input bit disturb, input logic [15:0] ed, input logic ee);
        for (int k = 0; k < D; k++) begin
            chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
            chk({tag, "_nodone"}, 16'(bus.done), 16'd0);
            if (disturb) begin
                bus.start = 1'($urandom);
                bus.din   = 16'($urandom);
                bus.dir   = 1'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_done"}, 16'(bus.done), 16'd1);
        chk({tag, "_busy_at_done"}, 16'(bus.busy), 16'd0);
        chk({tag, "_dout"}, bus.dout, ed);
        chk({tag, "_err"}, 16'(bus.err), 16'(ee));
    endtask

    task automatic conv(input string tag, input logic [15:0] d, input logic r, input bit disturb,
                        input logic [15:0] ed, input logic ee);
        start_conv(d, r);
        finish_conv(tag, disturb, ed, ee);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 16'(bus.done), 16'd0);
        chk({tag, "_idle"}, 16'(bus.busy), 16'd0);
        chk({tag, "_hold_dout"}, bus.dout, ed);
        chk({tag, "_hold_err"}, 16'(bus.err), 16'(ee));
    endtask

    initial begin
        logic [16:0] m;
        logic [15:0] d;
        logic        r;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.din   = '0;
        bus.dir   = 1'b0;
        #13;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);
        chk("rst_dout", bus.dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        conv("basic", 16'h1234, 1'b0, 1'b0, 16'h4567, 1'b0);
        conv("bnd_fwd", 16'h9090, 1'b0, 1'b0, 16'hC3C3, 1'b0);
        conv("bnd_rev", 16'hC3C3, 1'b1, 1'b0, 16'h9090, 1'b0);
        conv("ill_fwd", 16'h12A4, 1'b0, 1'b0, 16'h45F7, 1'b1);
        conv("ill_rev", 16'h2456, 1'b1, 1'b0, 16'hF123, 1'b1);
        conv("err_clr", 16'h0918, 1'b0, 1'b0, 16'h3C4B, 1'b0);
        conv("ignored", 16'h5678, 1'b0, 1'b1, 16'h89AB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignored_no_extra_done", 16'(bus.done), 16'd0);
        end
        start_conv(16'h2468, 1'b0);
        finish_conv("b2b_first", 1'b0, 16'h579B, 1'b0);
        bus.start = 1'b1;
        bus.din   = 16'h0000;
        bus.dir   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done_one_cycle", 16'(bus.done), 16'd0);
        finish_conv("b2b_second", 1'b0, 16'h3333, 1'b0);
        @(negedge clk);
        start_conv(16'h1234, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_done", 16'(bus.done), 16'd0);
        chk("abort_err", 16'(bus.err), 16'd0);
        chk("abort_dout", bus.dout, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_done", 16'(bus.done), 16'd0);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 16'(bus.done), 16'd0);
            chk("abort_no_busy", 16'(bus.busy), 16'd0);
        end
        conv("post_abort", 16'h8765, 1'b0, 1'b0, 16'hBA98, 1'b0);
        for (int i = 0; i < 24; i++) begin
            r = 1'($urandom);
            d = 16'($urandom);
            if (i % 2 == 0)
                for (int k = 0; k < D; k++)
                    d[4*k +: 4] = 4'(r ? $urandom_range(3, 12) : $urandom_range(0, 9));
            m = model(d, r);
            conv("rand", d, r, i % 3 == 0, m[15:0], m[16]);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcd_xs3_sequencer.md
# bcd_xs3_sequencer

Multi-digit BCD/excess-3 code converter that time-shares one 4-bit `adder_subtractor` across all digits of a packed word, one digit per clock. It accepts a start request, walks the digits LSD-first, and assembles the result. It flags any digit that is illegal in the source code, then reports completion with a one-cycle `done` pulse. It sits between a packed-digit producer (keypad/register file) and display or arithmetic logic that needs the other code.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1–16.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `start`  input  1: request a conversion; sampled on the rising edge of `clk`.
- `dir`  input  1: conversion direction, sampled with `start`. 0 = BCD→excess-3 (add 3, M=0); 1 = excess-3→BCD (subtract 3, M=1).
- `din`  input  4*DIGITS: packed source digits; digit k is `din[4k+3:4k]`, and digit 0 is least significant.
- `busy`  output  1: high while a conversion is in progress.
- `done`  output  1: one-cycle pulse when `dout`/`err` are valid.
- `dout`  output  4*DIGITS: packed converted digits, in the same layout as `din`.
- `err`  output  1: high if any source digit in the word was illegal; valid with `done`.

## Operation
- The block contains exactly one `adder_subtractor` instance.
  - Tie B = 4'b0011 and M = the latched `dir`.
  - A = the current source digit, selected by the digit index.
  - The carry output is unused.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: `busy`=0, `done`=0.
    - `start`=1 latches `din`→src register and `dir`→dir register.
    - It also clears idx and the `err` accumulator, then moves to RUN.
  - RUN: `busy`=1.
    - Each cycle, the adder result for src digit idx is written into `dout` slot idx, and idx increments.
    - When idx = DIGITS-1 is processed, move to DONE.
  - DONE: `done`=1 and `busy`=0 for exactly one cycle.
    - Next state is IDLE.
    - If `start`=1 in DONE, it is accepted exactly as in IDLE and the next state is RUN, so back-to-back conversions are supported.
- Legality of source digits:
  - dir=0: a digit is illegal if > 9.
  - dir=1: a digit is illegal if < 3 or > 12.
- For an illegal digit, the `dout` slot is written with 4'hF instead of the adder result, and the `err` accumulator sets. It stays set until the next accepted `start`.
- `start` while in RUN is ignored. `din` and `dir` changes during RUN have no effect.
- `dout` and `err` hold their last values from DONE until the next accepted `start`.
  - On accepting a new `start`, `err` is cleared.
  - `dout` slots are overwritten progressively during RUN.
- idx width is clog2(DIGITS), minimum 1 bit. When DIGITS=1, RUN lasts one cycle.

## Timing
- Reset (`rst_n`=0, any time, including mid-RUN) immediately forces:
  - state = IDLE
  - `busy`=0, `done`=0, `err`=0
  - `dout`=0, idx=0, src=0, dir=0
- An aborted conversion produces no `done`. Operation resumes on the first `clk` edge after `rst_n` deasserts.
- Latency: `start` sampled at edge E0 gives `busy`=1 for cycles E0..E0+DIGITS-1 and `done`=1 in the cycle after edge E0+DIGITS.
  - Total is DIGITS+1 cycles from `start` to `done`.
- Digit k's `dout` slot updates at edge E0+k+1. Consumers must only use `dout` qualified by `done`, or while `busy`=0.
- Adder path is purely combinational within one cycle: registered src digit → adder → `dout` slot register.
- `busy` and `done` are never high simultaneously.
- `done` pulse width is always exactly one cycle, including back-to-back conversions.

## Test plan
- Reset and basic conversion, DIGITS=4: apply reset, then `din`=16'h1234, dir=0, one-cycle `start`.
  - Required: `busy` high for 4 cycles; `done` pulses 5 cycles after `start`.
  - `dout`=16'h4567, `err`=0.
- Boundary digits: `din`=16'h9090, dir=0 → `dout`=16'hC3C3, `err`=0.
  - Then `din`=16'hC3C3, dir=1 → `dout`=16'h9090, `err`=0.
- Illegal digits:
  - `din`=16'h12A4, dir=0 → `dout`=16'h45F7, `err`=1.
  - Next, `din`=16'h2456, dir=1 → `dout`=16'hF123, `err`=1.
  - Next, a legal word → `err`=0.
- Ignored `start` and input changes: during RUN, pulse `start` and change `din`/`dir`.
  - Required: no restart; the original result is delivered; exactly one `done`.
- Back-to-back: assert `start` in the DONE cycle with `din`=16'h0000, dir=0.
  - Required: the first result is correct; `busy` rises the next cycle.
  - Second `done` arrives 5 cycles after the second `start`, with `dout`=16'h3333.
- Reset mid-operation: assert `rst_n`=0 asynchronously (not clock-aligned) after the 2nd RUN cycle.
  - Required: `busy`/`done`/`err`/`dout` go to 0 at once; no `done` follows.
  - A fresh `start` afterwards with 16'h8765, dir=0 yields 16'hBA98.
